// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads program memory through a ready
// handshake, and holds each fetched word until the control unit loads it into the IR.
module instruction_fetch_unit #(
  parameter int WORD_SIZE  = 19,
  parameter int ADDR_WIDTH = 14,
  parameter int RESET_PC   = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  fetch_en,
  input  logic                  ir_load,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ready,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic [WORD_SIZE-1:0]  instr_out,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  fetch_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   word_pc;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    start_fetch;
  logic                    capture;
  logic                    timeout;

  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    if (branch_valid) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state_next  = WAIT;
            start_fetch = 1'b1;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state_next = HOLD;
            capture    = 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state_next = IDLE;
            timeout    = 1'b1;
          end
        end
        HOLD: begin
          // Loading the IR frees the holding slot; fetch_en chains the next read.
          if (ir_load) begin
            if (fetch_en) begin
              state_next  = WAIT;
              start_fetch = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      pc          <= RESET_ADDR;
      word_pc     <= RESET_ADDR;
      mem_addr    <= RESET_ADDR;
      mem_rd      <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state     <= state_next;
      mem_rd    <= (state_next == WAIT);
      fetch_err <= timeout;

      if (start_fetch) begin
        mem_addr <= pc;
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // A branch discards any word arriving in the same cycle.
      if (branch_valid) begin
        pc          <= branch_target;
        instr_valid <= 1'b0;
        wait_cnt    <= '0;
      end else if (capture) begin
        instr_out   <= mem_rdata;
        instr_valid <= 1'b1;
        word_pc     <= pc;
        pc          <= pc + ADDR_WIDTH'(1);
      end else if (state == HOLD && ir_load) begin
        instr_valid <= 1'b0;
      end
    end
  end

  assign pc_out = instr_valid ? word_pc : pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: a program-memory model feeds the
// fetch unit while a scoreboard of expected (word, address) pairs is checked by a monitor.
module tb_instruction_fetch_unit;
  localparam int WS  = 19;
  localparam int AW  = 14;
  localparam int RPC = 0;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst_n, fetch_en, ir_load, branch_valid, mem_ready;
  logic [AW-1:0] branch_target, mem_addr, pc_out;
  logic [WS-1:0] mem_rdata, instr_out;
  logic          mem_rd, instr_valid, fetch_err;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST_N(rst_n), .fetch_en(fetch_en), .ir_load(ir_load),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [WS-1:0] word;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          sb[$];
  logic [WS-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_pc;
  int            checks = 0;
  int            errors = 0;

  task automatic chk_word(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every new word on instr_out must match the oldest expected entry.
  logic          mon_prev = 1'b0;
  logic [WS-1:0] mon_held = '0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (instr_valid && !mon_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got instr %0h at pc %0h, required no word", instr_out, pc_out);
          mon_held = instr_out;
        end else begin
          e = sb.pop_front();
          chk_word("instr_out", instr_out, e.word);
          chk_addr("pc_out_word", pc_out, e.pc);
          $display("word %05h from %04h delivered", instr_out, pc_out);
          mon_held = e.word;
        end
      end else if (instr_valid && mon_prev) begin
        chk_word("instr_hold", instr_out, mon_held);
      end
      mon_prev = instr_valid;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; ir_load = 1'b0; branch_valid = 1'b0; mem_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_pc = AW'(RPC);
    chk_bit("rst_rd", mem_rd, 1'b0);
    chk_bit("rst_valid", instr_valid, 1'b0);
    chk_bit("rst_err", fetch_err, 1'b0);
    chk_addr("rst_addr", mem_addr, exp_pc);
    chk_addr("rst_pc", pc_out, exp_pc);
    chk_word("rst_instr", instr_out, '0);
  endtask

  task automatic issue_request();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk_bit("req_rd", mem_rd, 1'b1);
    chk_addr("req_addr", mem_addr, exp_pc);
    chk_bit("req_valid", instr_valid, 1'b0);
  endtask

  // Memory answers on the lat-th cycle of the request; optional branch in that same cycle.
  task automatic serve(input int lat, input bit br, input logic [AW-1:0] tgt);
    for (int k = 1; k <= lat; k++) begin
      chk_bit("wait_rd", mem_rd, 1'b1);
      chk_bit("wait_valid", instr_valid, 1'b0);
      if (k == lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        if (br) begin
          branch_valid  = 1'b1;
          branch_target = tgt;
        end else begin
          sb.push_back('{word: mem[exp_pc], pc: exp_pc});
          exp_pc++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = WS'($urandom);
        fetch_en  = 1'($urandom_range(0, 1));
      end
      step();
    end
    mem_ready = 1'b0; branch_valid = 1'b0; fetch_en = 1'b0;
    mem_rdata = WS'($urandom);
    if (br) begin
      exp_pc = tgt;
      chk_bit("brw_valid", instr_valid, 1'b0);
      chk_bit("brw_rd", mem_rd, 1'b0);
      chk_addr("brw_pc", pc_out, tgt);
    end else begin
      chk_bit("got_valid", instr_valid, 1'b1);
      chk_bit("got_rd", mem_rd, 1'b0);
    end
  endtask

  // Spurious mem_ready and fetch_en while holding must change nothing.
  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = WS'($urandom);
      fetch_en  = 1'($urandom_range(0, 1));
      step();
      chk_bit("hold_valid", instr_valid, 1'b1);
      chk_bit("hold_rd", mem_rd, 1'b0);
    end
    mem_ready = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic consume(input bit b2b);
    ir_load = 1'b1; fetch_en = b2b;
    step();
    ir_load = 1'b0; fetch_en = 1'b0;
    chk_bit("ld_valid", instr_valid, 1'b0);
    if (b2b) begin
      chk_bit("b2b_rd", mem_rd, 1'b1);
      chk_addr("b2b_addr", mem_addr, exp_pc);
    end else begin
      chk_bit("ld_rd", mem_rd, 1'b0);
      chk_addr("idle_pc", pc_out, exp_pc);
    end
  endtask

  task automatic branch_now(input logic [AW-1:0] tgt, input bit with_load);
    branch_valid = 1'b1; branch_target = tgt; ir_load = with_load;
    fetch_en = 1'($urandom_range(0, 1));
    step();
    branch_valid = 1'b0; ir_load = 1'b0; fetch_en = 1'b0;
    exp_pc = tgt;
    chk_bit("br_valid", instr_valid, 1'b0);
    chk_bit("br_rd", mem_rd, 1'b0);
    chk_addr("br_pc", pc_out, tgt);
  endtask

  // Entered on the first request cycle; the read must stay up for TO cycles.
  task automatic timeout_seq();
    for (int i = 1; i < TO; i++) begin
      step();
      chk_bit("to_rd", mem_rd, 1'b1);
      chk_bit("to_err_early", fetch_err, 1'b0);
    end
    step();
    chk_bit("to_err_pulse", fetch_err, 1'b1);
    chk_bit("to_rd_drop", mem_rd, 1'b0);
    chk_bit("to_valid", instr_valid, 1'b0);
    step();
    chk_bit("to_err_once", fetch_err, 1'b0);
    chk_addr("to_pc", pc_out, exp_pc);
    $display("timeout at %04h flagged", exp_pc);
  endtask

  task automatic reset_mid_wait();
    step();
    rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = WS'($urandom);
    step();
    rst_n = 1'b1;
    exp_pc = AW'(RPC);
    chk_bit("rstw_rd", mem_rd, 1'b0);
    chk_bit("rstw_valid", instr_valid, 1'b0);
    chk_addr("rstw_pc", pc_out, exp_pc);
    chk_addr("rstw_addr", mem_addr, exp_pc);
    step();
    mem_ready = 1'b0;
    chk_bit("late_ready_valid", instr_valid, 1'b0);
    chk_bit("late_ready_rd", mem_rd, 1'b0);
  endtask

  initial begin
    bit pending;
    int r;
    logic [AW-1:0] tgt;
    mem_rdata = '0; branch_target = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = WS'($urandom);
    mem[0] = 19'h12345;
    do_reset();

    // Sequential fetches: first with single-cycle memory, then three-cycle memory.
    issue_request(); serve(1, 0, '0); consume(1);
    serve(3, 0, '0); consume(1);
    serve(3, 0, '0); consume(1);
    serve(3, 0, '0); hold_idle(2); consume(0);

    // PC wrap from the top of memory.
    branch_now(14'h3FFF, 0);
    issue_request(); serve(2, 0, '0); consume(1);
    serve(1, 0, '0); consume(0);

    // Timeout then retry of the same address.
    issue_request(); timeout_seq();
    issue_request(); serve(2, 0, '0); consume(0);

    // Branch racing mem_ready, then branch together with ir_load in HOLD.
    issue_request(); serve(2, 1, 14'h0200);
    issue_request(); serve(1, 0, '0); hold_idle(1);
    branch_now(14'h0123, 1);

    issue_request(); reset_mid_wait();

    pending = 0;
    for (int it = 0; it < 300; it++) begin
      if (!pending) issue_request();
      r = $urandom_range(0, 19);
      tgt = (($urandom_range(0, 7)) == 0) ? 14'h3FFF : AW'($urandom);
      if (r == 0) begin
        timeout_seq();
        pending = 0;
      end else if (r < 3) begin
        serve($urandom_range(1, 5), 1, tgt);
        pending = 0;
      end else begin
        serve($urandom_range(1, 5), 0, '0);
        hold_idle($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) begin
          branch_now(tgt, 1);
          pending = 0;
        end else begin
          pending = 1'($urandom_range(0, 1));
          consume(pending);
        end
      end
    end
    if (pending) begin
      serve(1, 0, '0);
      consume(0);
    end
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending words, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of instruction_register; owns the program counter (PC).
- Reads one 19-bit instruction word per fetch from program memory via a ready handshake.
- Holds each fetched word on instr_out until the control unit loads it into the IR, then advances.
- Accepts branch redirects from the control unit. Flags memory timeouts.

Parameters:
- WORD_SIZE, 19, instruction word width (5-bit opcode + 14-bit operand).
- ADDR_WIDTH, 14, PC and memory address width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 16, maximum cycles in WAIT without mem_ready before fetch_err.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- fetch_en  in  1  control unit permits fetching
- ir_load  in  1  IR captures instr_out this cycle (LOAD_REG with LOAD_SELECT==LOAD_IR)
- branch_valid  in  1  redirect PC
- branch_target  in  ADDR_WIDTH  new PC on branch
- mem_addr  out  ADDR_WIDTH  program memory read address
- mem_rd  out  1  read request
- mem_ready  in  1  memory data valid
- mem_rdata  in  WORD_SIZE  memory read data
- instr_out  out  WORD_SIZE  to instruction_bus.instr_in
- instr_valid  out  1  instr_out holds an unconsumed word
- pc_out  out  ADDR_WIDTH  address of the word in instr_out, or of the next fetch when idle
- fetch_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (RST_N low at a CLK edge):
  - pc=RESET_PC, state=IDLE, mem_rd=0, mem_addr=RESET_PC, instr_out=0, instr_valid=0, fetch_err=0, timeout counter=0.
  - Reset overrides an in-flight read. The data is discarded, and mem_rd is low the cycle after reset.
- States:
  - IDLE: mem_rd=0. If fetch_en is high, go to WAIT with mem_addr=pc and mem_rd=1, registered. The request is visible the cycle after fetch_en is sampled.
  - WAIT: mem_rd=1 and mem_addr is held stable. The counter increments each cycle.
    - On mem_ready: instr_out<=mem_rdata, instr_valid<=1, pc_out<=pc, pc<=pc+1, mem_rd<=0, then go to HOLD.
    - PC increment is modulo 2^ADDR_WIDTH, so 16383 wraps to 0.
    - If the counter reaches TIMEOUT-1 with no mem_ready: pulse fetch_err, mem_rd<=0, go to IDLE. pc is unchanged and instr_valid stays 0. A later fetch_en retries the same address.
  - HOLD: instr_out and instr_valid are stable. On ir_load: instr_valid<=0. If fetch_en is also high, go directly to WAIT with mem_addr=pc (back-to-back fetch); otherwise go to IDLE.
- ir_load while instr_valid=0 is ignored.
- Latency:
  - A fetch takes 1 cycle from fetch_en to mem_rd, plus the memory latency.
  - With mem_ready returned 1 cycle after mem_rd, instr_valid rises 2 cycles after fetch_en.
- Branch (branch_valid=1) has the highest priority after reset, in any state:
  - pc<=branch_target, instr_valid<=0, mem_rd<=0, state<=IDLE, counter cleared.
  - Any mem_ready/mem_rdata in the same cycle is discarded.
  - In HOLD, branch_valid and ir_load together: the IR still captures the current instr_out (the word is valid that cycle), and no increment occurs.
- fetch_en dropping while in WAIT does not abort the outstanding read. Only a branch or reset aborts it.
- mem_ready outside WAIT is ignored.
- fetch_err is high for exactly one cycle per timeout.

Test Plan:
- Reset then fetch_en=1, memory returns 19'h1_2345 at addr 0 with 1-cycle latency -> mem_rd high at cycle 1, instr_out=19'h12345, instr_valid=1 at cycle 2, pc_out=0, pc=1.
- HOLD with ir_load=1 and fetch_en=1 held, memory 3-cycle latency -> next mem_addr=1 the cycle after ir_load; instr_valid low until the word arrives. Issue 4 sequential fetches and check addresses 0..3.
- RESET_PC=16383, one fetch -> pc wraps to 0, next mem_addr=0.
- mem_ready never asserted, TIMEOUT=16 -> fetch_err one-cycle pulse after 16 WAIT cycles, mem_rd drops, a retry uses the same address.
- branch_valid with target 14'h0200 in the same cycle as mem_ready in WAIT -> data discarded, instr_valid=0, next fetch mem_addr=14'h0200.
- RST_N low mid-WAIT -> mem_rd=0, pc=RESET_PC next cycle; a late mem_ready is ignored and instr_valid stays 0.
